// File: rtl/baud_rate_ctrl.sv
// Baud generator reconfiguration sequencer: waits for an idle transmitter, writes the
// 16-bit divisor as two back-to-back byte writes, then confirms ticks under a timeout.
module baud_rate_ctrl #(
  parameter int SETTLE_TICKS = 2,
  parameter int TIMEOUT_CYC  = 2048,
  parameter int IDLE_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        use_custom,
  input  logic [1:0]  rate_sel,
  input  logic [15:0] custom_div,
  input  logic        tx_busy,
  input  logic        transmit_baud,
  output logic        baud_write_en,
  output logic        baud_write_location,
  output logic [7:0]  baud_generator_write_line,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] cur_div
);

  localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam int WAIT_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int TICK_W = $clog2(SETTLE_TICKS + 1);
  localparam logic [15:0] RESET_DIV = 16'd326;

  typedef enum logic [2:0] {IDLE, WAIT_IDLE, WR_LOW, WR_HIGH, SETTLE} state_t;

  state_t            state, state_nxt;
  logic [15:0]       pend_div, pend_nxt, cur_nxt, table_div, sel_div;
  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic [TICK_W-1:0] tick_cnt, tick_nxt, tick_sum;
  logic [TO_W-1:0]   to_cnt, to_nxt, to_sum;
  logic              we_nxt, loc_nxt, busy_nxt, done_nxt, err_nxt;
  logic [7:0]        line_nxt;

  always_comb begin
    case (rate_sel)
      2'd0:    table_div = 16'd651;
      2'd1:    table_div = 16'd326;
      2'd2:    table_div = 16'd163;
      default: table_div = 16'd81;
    endcase
    sel_div  = use_custom ? custom_div : table_div;
    tick_sum = tick_cnt + TICK_W'(transmit_baud);
    to_sum   = to_cnt + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend_div;
    cur_nxt   = cur_div;
    wait_nxt  = wait_cnt;
    tick_nxt  = tick_cnt;
    to_nxt    = to_cnt;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          pend_nxt = sel_div;
          wait_nxt = '0;
          if (sel_div == 16'd0) err_nxt = 1'b1;
          else                  state_nxt = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (!tx_busy) begin
          state_nxt = WR_LOW;
        end else if (wait_cnt == WAIT_W'(IDLE_TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
      end
      WR_LOW: state_nxt = WR_HIGH;
      WR_HIGH: begin
        state_nxt = SETTLE;
        cur_nxt   = pend_div;
        tick_nxt  = '0;
        to_nxt    = '0;
      end
      SETTLE: begin
        tick_nxt = tick_sum;
        to_nxt   = to_sum;
        // A tick arriving on the timeout cycle still counts as success.
        if (tick_sum >= TICK_W'(SETTLE_TICKS)) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if (to_sum >= TO_W'(TIMEOUT_CYC)) begin
          err_nxt   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
    we_nxt   = (state_nxt == WR_LOW) || (state_nxt == WR_HIGH);
    loc_nxt  = (state_nxt == WR_HIGH);
    if (state_nxt == WR_LOW)       line_nxt = pend_nxt[7:0];
    else if (state_nxt == WR_HIGH) line_nxt = pend_nxt[15:8];
    else                           line_nxt = 8'd0;
  end

  // Outputs are registered from next-state decode so they line up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                     <= IDLE;
      pend_div                  <= 16'd0;
      cur_div                   <= RESET_DIV;
      wait_cnt                  <= '0;
      tick_cnt                  <= '0;
      to_cnt                    <= '0;
      baud_write_en             <= 1'b0;
      baud_write_location       <= 1'b0;
      baud_generator_write_line <= 8'd0;
      busy                      <= 1'b0;
      done                      <= 1'b0;
      err                       <= 1'b0;
    end else begin
      state                     <= state_nxt;
      pend_div                  <= pend_nxt;
      cur_div                   <= cur_nxt;
      wait_cnt                  <= wait_nxt;
      tick_cnt                  <= tick_nxt;
      to_cnt                    <= to_nxt;
      baud_write_en             <= we_nxt;
      baud_write_location       <= loc_nxt;
      baud_generator_write_line <= line_nxt;
      busy                      <= busy_nxt;
      done                      <= done_nxt;
      err                       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_baud_rate_ctrl.sv
// Self-checking bench for baud_rate_ctrl: a cycle-stamp model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_baud_rate_ctrl;

  localparam int SETTLE_TICKS = 2;
  localparam int TIMEOUT_CYC  = 2048;
  localparam int IDLE_TIMEOUT = 65535;
  localparam int TICK_PERIOD  = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req = 1'b0;
  logic        use_custom = 1'b0;
  logic [1:0]  rate_sel = 2'd0;
  logic [15:0] custom_div = 16'd0;
  logic        tx_busy = 1'b0;
  logic        transmit_baud = 1'b0;
  logic        baud_write_en, baud_write_location, busy, done, err;
  logic [7:0]  baud_generator_write_line;
  logic [15:0] cur_div;

  int n_compared = 0;
  int n_mismatched = 0;
  bit check_en = 1'b0;
  bit tick_en = 1'b0;

  baud_rate_ctrl #(
    .SETTLE_TICKS(SETTLE_TICKS), .TIMEOUT_CYC(TIMEOUT_CYC), .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .use_custom(use_custom), .rate_sel(rate_sel),
    .custom_div(custom_div), .tx_busy(tx_busy), .transmit_baud(transmit_baud),
    .baud_write_en(baud_write_en), .baud_write_location(baud_write_location),
    .baud_generator_write_line(baud_generator_write_line), .busy(busy), .done(done),
    .err(err), .cur_div(cur_div)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    n_compared++;
    if (actual !== required) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  function automatic logic [15:0] rate_table(input logic [1:0] s);
    case (s)
      2'd0:    return 16'd651;
      2'd1:    return 16'd326;
      2'd2:    return 16'd163;
      default: return 16'd81;
    endcase
  endfunction

  // Model: tracks the request by absolute edge numbers; the write pair and the
  // settle window are placed relative to the edge at which tx_busy was seen low.
  int          edge_no, m_wait, m_write_at, m_ticks;
  bit          m_active, m_waiting;
  logic [15:0] m_pend, m_cur;
  logic        e_we, e_loc, e_busy, e_done, e_err;
  logic [7:0]  e_line;
  logic [15:0] e_cur;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edge_no = 0; m_active = 0; m_waiting = 0; m_write_at = -100; m_wait = 0; m_ticks = 0;
      m_pend = 16'd0; m_cur = 16'd326;
      e_we = 0; e_loc = 0; e_line = 8'd0; e_busy = 0; e_done = 0; e_err = 0; e_cur = 16'd326;
    end else begin
      edge_no++;
      e_done = 0;
      e_err  = 0;
      if (!m_active) begin
        if (req) begin
          m_pend = use_custom ? custom_div : rate_table(rate_sel);
          if (m_pend == 16'd0) e_err = 1;
          else begin m_active = 1; m_waiting = 1; m_wait = 0; end
        end
      end else if (m_waiting) begin
        if (!tx_busy) begin
          m_waiting = 0; m_write_at = edge_no; m_ticks = 0;
        end else begin
          m_wait++;
          if (m_wait == IDLE_TIMEOUT) begin e_err = 1; m_active = 0; m_waiting = 0; end
        end
      end else if (edge_no == m_write_at + 2) begin
        m_cur = m_pend;
      end else if (edge_no > m_write_at + 2) begin
        if (transmit_baud) m_ticks++;
        if (m_ticks >= SETTLE_TICKS) begin e_done = 1; m_active = 0; end
        else if (edge_no - (m_write_at + 2) >= TIMEOUT_CYC) begin e_err = 1; m_active = 0; end
      end
      e_busy = m_active;
      e_we   = m_active && (edge_no == m_write_at || edge_no == m_write_at + 1);
      e_loc  = m_active && (edge_no == m_write_at + 1);
      e_line = !e_we ? 8'd0 : (e_loc ? m_pend[15:8] : m_pend[7:0]);
      e_cur  = m_cur;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("model_we",   32'(baud_write_en),             32'(e_we));
      checkOutput("model_loc",  32'(baud_write_location),       32'(e_loc));
      checkOutput("model_line", 32'(baud_generator_write_line), 32'(e_line));
      checkOutput("model_busy", 32'(busy),                      32'(e_busy));
      checkOutput("model_done", 32'(done),                      32'(e_done));
      checkOutput("model_err",  32'(err),                       32'(e_err));
      checkOutput("model_cur",  32'(cur_div),                   32'(e_cur));
    end
  end

  // Free-running baud tick source, one-cycle pulse every TICK_PERIOD cycles.
  initial begin
    int phase = 0;
    forever begin
      @(negedge clk);
      #1;
      transmit_baud = tick_en && (phase == 0);
      phase = (phase + 1) % TICK_PERIOD;
    end
  end

  task automatic applyStimulus(input logic custom, input logic [1:0] sel, input logic [15:0] div);
    @(negedge clk);
    #1;
    req = 1'b1; use_custom = custom; rate_sel = sel; custom_div = div;
    @(negedge clk);
    #1;
    req = 1'b0;
  endtask

  // kind 0: wait for a write strobe; kind 1: wait for done or err.
  task automatic wait_event(input int kind, input int budget, output int cycles);
    bit hit;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      hit = (kind == 0) ? baud_write_en : (done || err);
    end while (!hit && cycles < budget);
    checkOutput(kind == 0 ? "wait_write" : "wait_finish", 32'(hit), 32'd1);
  endtask

  task automatic check_write_pair(input logic [7:0] lo, input logic [7:0] hi);
    checkOutput("low_loc",  32'(baud_write_location), 32'd0);
    checkOutput("low_line", 32'(baud_generator_write_line), 32'(lo));
    @(negedge clk);
    checkOutput("high_we",   32'(baud_write_en), 32'd1);
    checkOutput("high_loc",  32'(baud_write_location), 32'd1);
    checkOutput("high_line", 32'(baud_generator_write_line), 32'(hi));
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("rst_we",   32'(baud_write_en), 32'd0);
    checkOutput("rst_line", 32'(baud_generator_write_line), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_cur",  32'(cur_div), 32'd326);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int cyc, n_done, n_we;
    #1 rst = 1'b1;
    #4 check_en = 1'b1;
    checkOutput("init_cur",  32'(cur_div), 32'd326);
    checkOutput("init_done", 32'(done), 32'd0);
    checkOutput("init_err",  32'(err), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    $display("[TB] zero divisor rejected");
    applyStimulus(1'b1, 2'd0, 16'd0);
    checkOutput("zero_err",  32'(err), 32'd1);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    checkOutput("zero_cur",  32'(cur_div), 32'd326);
    @(negedge clk);
    checkOutput("zero_err_clear", 32'(err), 32'd0);

    $display("[TB] table rate 19200");
    tick_en = 1'b1;
    applyStimulus(1'b0, 2'd2, 16'd0);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    wait_event(0, 20, cyc);
    check_write_pair(8'hA3, 8'h00);
    wait_event(1, 100, cyc);
    checkOutput("t1_done", 32'(done), 32'd1);
    checkOutput("t1_busy_low", 32'(busy), 32'd0);
    checkOutput("t1_cur", 32'(cur_div), 32'd163);

    $display("[TB] custom divisor behind busy transmitter");
    tx_busy = 1'b1;
    applyStimulus(1'b1, 2'd0, 16'h028B);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      checkOutput("t2_no_write", 32'(baud_write_en), 32'd0);
    end
    #1 tx_busy = 1'b0;
    wait_event(0, 20, cyc);
    check_write_pair(8'h8B, 8'h02);
    wait_event(1, 100, cyc);
    checkOutput("t2_done", 32'(done), 32'd1);
    checkOutput("t2_cur", 32'(cur_div), 32'd651);

    $display("[TB] settle timeout with no ticks");
    tick_en = 1'b0;
    repeat (3) @(negedge clk);
    applyStimulus(1'b0, 2'd3, 16'd0);
    wait_event(0, 20, cyc);
    check_write_pair(8'h51, 8'h00);
    wait_event(1, TIMEOUT_CYC + 100, cyc);
    checkOutput("t4_err_cycle", 32'(cyc), 32'd2049);
    checkOutput("t4_err", 32'(err), 32'd1);
    checkOutput("t4_no_done", 32'(done), 32'd0);
    checkOutput("t4_cur", 32'(cur_div), 32'd81);

    $display("[TB] request during settle ignored");
    tick_en = 1'b1;
    applyStimulus(1'b0, 2'd0, 16'd0);
    wait_event(0, 20, cyc);
    check_write_pair(8'h8B, 8'h02);
    applyStimulus(1'b0, 2'd3, 16'd0);
    n_done = 0;
    n_we = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) n_done++;
      if (baud_write_en) n_we++;
    end
    checkOutput("t5_done_count", 32'(n_done), 32'd1);
    checkOutput("t5_write_count", 32'(n_we), 32'd0);
    checkOutput("t5_cur", 32'(cur_div), 32'd651);

    $display("[TB] reset between low and high byte writes");
    applyStimulus(1'b0, 2'd2, 16'd0);
    wait_event(0, 20, cyc);
    checkOutput("t6_low_line", 32'(baud_generator_write_line), 32'hA3);
    #1 rst = 1'b1;
    #1;
    checkOutput("t6_we",   32'(baud_write_en), 32'd0);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_cur",  32'(cur_div), 32'd326);
    @(negedge clk);
    #1 rst = 1'b0;
    n_we = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (baud_write_en) n_we++;
    end
    checkOutput("t6_no_high", 32'(n_we), 32'd0);
    checkOutput("t6_cur_after", 32'(cur_div), 32'd326);

    do_reset();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
